ins_mem_loader: RTL and testbench

- Write-side companion to the instruction memory: accepts a byte stream from a host/boot link and packs it into 32-bit instruction words.
- Writes each word into a writable instruction RAM through a single-cycle write strobe.
- Holds the CPU off the instruction memory while loading; InsMemRW=0 during loading, 1 otherwise.
- Sits between the boot/debug byte source and the instruction memory write port; releases the CPU when the programmed word count is written.

---
 rtl/ins_mem_loader.sv | 116 +++++++++++
 tb/tb_ins_mem_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_mem_loader
// Purpose  : Packs a big-endian byte stream into 32-bit words and writes them
//            into the instruction RAM while holding the CPU off it.
// Revision : 1.0 - initial release
// ============================================================================
module ins_mem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              abort,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              InsMemRW,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_load  = 2'd1;
  localparam logic [1:0] c_write = 2'd2;
  localparam logic [1:0] c_done  = 2'd3;

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_target;
  logic [ADDR_W:0]   r_word_idx;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;

  logic [ADDR_W:0]   w_next_idx;
  logic              w_accept;

  assign w_next_idx = r_word_idx + c_one;
  assign w_accept   = byte_valid && (r_state == c_load);

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      r_state     <= c_idle;
      r_target    <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= '0;
      r_word      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          // abort outranks start so a simultaneous pair leaves us idle
          if (start && !abort) begin
            r_target   <= (word_count > c_depth) ? c_depth : word_count;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_state    <= (word_count == '0) ? c_done : c_load;
          end
        end
        c_load: begin
          if (abort) begin
            r_state <= c_idle;
          end else if (w_accept) begin
            r_word <= {r_word[15:0], byte_in};
            if (r_byte_cnt == 2'd3) begin
              r_mem_wdata <= {r_word, byte_in};
              r_mem_addr  <= r_word_idx[ADDR_W-1:0];
              r_byte_cnt  <= '0;
              r_state     <= c_write;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end
        end
        c_write: begin
          // the strobe in this cycle always lands, even when aborting
          r_word_idx <= w_next_idx;
          if (abort) begin
            r_state <= c_idle;
          end else if (w_next_idx == r_target) begin
            r_state <= c_done;
          end else begin
            r_state <= c_load;
          end
        end
        c_done: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign byte_ready = (r_state == c_load);
  assign mem_we     = (r_state == c_write);
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign busy       = (r_state == c_load) || (r_state == c_write);
  assign InsMemRW   = (r_state == c_idle) || (r_state == c_done);
  assign done       = (r_state == c_done);

endmodule
`default_nettype wire

// File: tb/tb_ins_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_mem_loader
// Purpose  : Randomised scoreboard bench for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_mem_loader;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              CLK = 1'b0;
  logic              Reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              abort = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              InsMemRW;
  logic              busy;
  logic              done;

  ins_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .InsMemRW(InsMemRW), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -10;
  logic [35:0] exp_wr[$];
  bit          exp_done[$];
  logic [7:0]  fixed_q[$];
  logic [35:0] e_wr;
  bit          e_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: pops expected writes/done tokens as the DUT shows them
  always @(negedge CLK) begin
    cyc++;
    chk("rw_vs_busy", InsMemRW, !busy);
    if (mem_we) begin
      last_we_cyc = cyc;
      if (exp_wr.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h required none", mem_addr, mem_wdata);
      end else begin
        e_wr = exp_wr.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e_wr[35:32]));
        chk("wr_data", 64'(mem_wdata), 64'(e_wr[31:0]));
      end
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 required 0");
      end else begin
        e_done = exp_done.pop_front();
        if (e_done) chk("done_latency", 64'(cyc - last_we_cyc), 64'd1);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_insmemrw", InsMemRW, 1'b1);
  endtask

  // One load session; abort_at = index of the byte before which abort fires (-1 none)
  task automatic session(input int cnt, input int vmode, input int abort_at, input bit glitch);
    int tgt;
    int nwr;
    int nsent;
    int budget;
    bit v;
    bit rdy;
    logic [7:0] bq[$];
    tgt = (cnt > DEPTH) ? DEPTH : cnt;
    nsent = 0;
    budget = 0;
    for (int i = 0; i < 4*tgt; i++) begin
      if (fixed_q.size() > 0) bq.push_back(fixed_q.pop_front());
      else bq.push_back(8'($urandom_range(0, 255)));
    end
    nwr = (abort_at < 0) ? tgt : abort_at / 4;
    for (int w = 0; w < nwr; w++)
      exp_wr.push_back({4'(w), bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]});
    if (abort_at < 0) exp_done.push_back(tgt > 0);

    @(negedge CLK);
    start = 1'b1;
    word_count = (ADDR_W+1)'(cnt);
    @(negedge CLK);
    start = 1'b0;
    if (tgt == 0) begin
      chk("zero_done", done, 1'b1);
      chk("zero_insmemrw", InsMemRW, 1'b1);
    end

    while (nsent < 4*tgt && budget < 1000) begin
      if (nsent == abort_at) begin
        abort = 1'b1;
        byte_valid = 1'b0;
        @(negedge CLK);
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_insmemrw", InsMemRW, 1'b1);
        break;
      end
      case (vmode)
        0:       v = 1'b1;
        1:       v = (budget % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_in = v ? bq[nsent] : 8'($urandom_range(0, 255));
      rdy = byte_ready;
      if (glitch && budget == 3) begin
        start = 1'b1;
        word_count = (ADDR_W+1)'($urandom_range(0, 31));
      end
      @(negedge CLK);
      start = 1'b0;
      budget++;
      if (v && rdy) nsent++;
    end
    byte_valid = 1'b0;
    if (budget >= 1000) begin
      checks++; errors++;
      $display("FAIL session_timeout: got %0d bytes required %0d", nsent, 4*tgt);
    end
    repeat (4) @(negedge CLK);
    chk("writes_drained", 64'(exp_wr.size()), 64'd0);
    chk("done_drained", 64'(exp_done.size()), 64'd0);
  endtask

  // Reset lands on the edge closing the second write of a three-word load
  task automatic reset_during_write();
    logic [7:0] bq[$];
    int nsent;
    int budget;
    nsent = 0;
    budget = 0;
    for (int i = 0; i < 12; i++) bq.push_back(8'($urandom_range(0, 255)));
    for (int w = 0; w < 2; w++)
      exp_wr.push_back({4'(w), bq[4*w], bq[4*w+1], bq[4*w+2], bq[4*w+3]});
    @(negedge CLK);
    start = 1'b1;
    word_count = 5'd3;
    @(negedge CLK);
    start = 1'b0;
    while (budget < 200) begin
      byte_valid = 1'b1;
      byte_in = bq[nsent];
      if (byte_ready) nsent++;
      @(negedge CLK);
      budget++;
      if (mem_we && nsent == 8) begin
        Reset = 1'b0;
        byte_valid = 1'b0;
        break;
      end
    end
    if (budget >= 200) begin
      checks++; errors++;
      $display("FAIL rwr_timeout: got %0d bytes required 8", nsent);
    end
    @(negedge CLK);
    chk_reset_vals();
    Reset = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rwr_drained", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    Reset = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset_vals();
    Reset = 1'b1;

    fixed_q = '{8'h04, 8'h01, 8'h00, 8'h08, 8'h40, 8'h02, 8'h00, 8'h0C};
    session(2, 0, -1, 1'b0);
    fixed_q = '{8'h04, 8'h01, 8'h00, 8'h08, 8'h40, 8'h02, 8'h00, 8'h0C};
    session(2, 1, -1, 1'b0);
    session(0, 0, -1, 1'b0);
    session(20, 0, -1, 1'b0);
    session(5, 2, 6, 1'b0);
    session(3, 0, -1, 1'b0);
    session(4, 0, -1, 1'b1);
    reset_during_write();
    session(2, 2, -1, 1'b0);
    for (int k = 0; k < 8; k++)
      session($urandom_range(0, 20), $urandom_range(0, 2), -1, 1'($urandom_range(0, 1)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
